hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline controller for the RV32I five-stage core. Watches the register operands and destination of the instruction in decode, and tracks destinations in flight in EX/MEM/WB.
- Generates stall, bubble and flush controls for fetch/decode/execute, forwarding selects for the execute operand muxes, and the registered PC redirect for fetch.
- Sequences the decode stage; owns no datapath registers beyond its own scoreboard.

Parameters:
- LOAD_STALL_CYCLES, 1, cycles decode is held on a load-use hazard (1..3).
- FLUSH_CYCLES, 1, cycles flush stays asserted after a redirect (1..3).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- dec_valid_i  in  1  decode holds a valid instruction
- dec_rs1_addr_i  in  5  decode rs1 index
- dec_rs2_addr_i  in  5  decode rs2 index
- dec_uses_rs1_i  in  1  instruction reads rs1
- dec_uses_rs2_i  in  1  instruction reads rs2
- dec_rd_addr_i  in  5  decode destination
- dec_rd_wr_i  in  1  decode writes rd
- dec_is_load_i  in  1  decode is LB/LH/LW/LBU/LHU
- ex_redirect_i  in  1  EX resolved taken branch/JAL/JALR
- ex_target_i  in  32  redirect target
- stall_fetch_o  out  1  hold PC and fetch register
- stall_decode_o  out  1  hold decode register
- bubble_ex_o  out  1  load NOP into ID/EX
- flush_decode_o  out  1  invalidate IF/ID
- flush_execute_o  out  1  invalidate ID/EX
- fwd_rs1_sel_o  out  2  fwd_sel_e for operand 1
- fwd_rs2_sel_o  out  2  fwd_sel_e for operand 2
- redirect_valid_o  out  1  fetch loads redirect_pc_o
- redirect_pc_o  out  32  new PC

Behaviour:
- Reset (async assert, sync release): state RUN; scoreboard cleared; counters 0; all registered outputs 0; redirect_pc_o 0.
- Scoreboard: three entries EX/MEM/WB, each {valid, rd, is_load}.
  - Shifts every cycle: EX->MEM->WB, WB dropped.
  - The EX slot loads the decode instruction when dec_valid_i && dec_rd_wr_i && dec_rd_addr_i!=0 and no stall or flush; otherwise the slot is loaded invalid.
- Forwarding (combinational, same cycle): for each source with uses=1 and addr!=0, the youngest match wins.
  - EX match with !is_load: FWD_EX=1.
  - Else MEM match: FWD_MEM=2.
  - Else WB match: FWD_WB=3.
  - Else FWD_RF=0.
  - x0 always FWD_RF.
- FSM:
  - RUN. A load-use hazard is: EX valid && is_load && rd matches a used source && dec_valid_i. On a hazard, go to LOAD_STALL, counter = LOAD_STALL_CYCLES-1.
  - LOAD_STALL. stall_fetch_o=stall_decode_o=bubble_ex_o=1, combinationally from the hazard cycle onward. Counter decrements; at 0, return to RUN. Forwarding recomputes once the load reaches MEM.
  - FLUSH. Entered the cycle after ex_redirect_i. flush_decode_o=flush_execute_o=1 for FLUSH_CYCLES cycles, then RUN. The scoreboard EX slot is forced invalid while flushing.
- Redirect: ex_redirect_i in cycle N gives redirect_valid_o=1 and redirect_pc_o=ex_target_i in cycle N+1, both registered and pulsed for one cycle.
- Simultaneous events:
  - Redirect beats load-use: abort the stall and go to FLUSH.
  - Redirect while in FLUSH: restart the counter and latch the new target.
  - dec_valid_i=0 never stalls.
- Stall and flush outputs are never asserted together; flush has priority.
- Reset mid-stall/flush: outputs drop to 0 asynchronously.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: three 32-bit saturating counters, exposed as extra output ports perf_stall_cycles_o, perf_flush_events_o and perf_fwd_hits_o. Each increments per stall cycle, per redirect, or per non-RF forward selection respectively. All reset to 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- riscv_pkg gains:
  - fwd_sel_e {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}
  - hazard_state_e {RUN, LOAD_STALL, FLUSH}
  - sb_entry_t {valid, rd[4:0], is_load}
- Sub-module hazard_scoreboard: the 3-entry shift register plus match/forward-select logic. The FSM and redirect registers stay in hazard_ctrl.

Test Plan:
- Back-to-back dependency: ADD x5 then ADD x6,x5,x1 -> cycle 2 fwd_rs1_sel_o=FWD_EX, no stall; a further ADD x7,x5 two cycles later -> FWD_MEM.
- Load-use: LW x5 then ADD x6,x5,x2 -> stall_fetch_o/stall_decode_o/bubble_ex_o=1 for exactly 1 cycle; next cycle fwd_rs1_sel_o=FWD_MEM.
- x0 write/read: ADDI x0 then ADD x1,x0,x0 -> both selects FWD_RF, no stall.
- Redirect: ex_redirect_i=1, ex_target_i=0x0000_0100 in cycle N -> cycle N+1 redirect_valid_o=1 with pc 0x100, flushes high for 1 cycle, scoreboard EX invalid.
- Redirect coincides with load-use hazard -> no stall asserted, FLUSH taken, redirect pc correct.
- Assert rstn_i low mid LOAD_STALL -> all outputs 0 immediately; after release, state RUN with an empty scoreboard.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared hazard-control types and helpers for the RV32I five-stage core.
// Contents: fwd_sel_e (execute operand source), hazard_state_e (decode sequencer
// state), sb_entry_t (one in-flight destination), fwd_pick (youngest-match select)
// and sat_add (32-bit saturating add for the optional perf counters).
package riscv_pkg;
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    // Index 0 is EX (youngest), 1 is MEM, 2 is WB. A load still in EX has no
    // data to forward, so it is skipped and older stages are considered.
    function automatic fwd_sel_e fwd_pick(sb_entry_t [2:0] sb, logic used, logic [4:0] addr);
        if (!used || addr == 5'd0) return FWD_RF;
        if (sb[0].valid && sb[0].rd == addr && !sb[0].is_load) return FWD_EX;
        if (sb[1].valid && sb[1].rd == addr) return FWD_MEM;
        if (sb[2].valid && sb[2].rd == addr) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic logic [31:0] sat_add(logic [31:0] a, logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: three-entry EX/MEM/WB destination tracker with forwarding selects.
// Ports: clk, rst_n (async active-low); load_en/rd_addr/is_load fill the EX slot;
// rs1_addr/rs2_addr/uses_rs1/uses_rs2 describe the decode sources; fwd_rs1_sel and
// fwd_rs2_sel are the combinational operand selects; load_use flags a source that
// depends on a load still sitting in EX.
module hazard_scoreboard
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [4:0] rd_addr,
    input  logic       is_load,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    output fwd_sel_e   fwd_rs1_sel,
    output fwd_sel_e   fwd_rs2_sel,
    output logic       load_use
);
    sb_entry_t [2:0] sb;
    sb_entry_t       ex_next;

    assign ex_next = load_en ? sb_entry_t'{valid: 1'b1, rd: rd_addr, is_load: is_load} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sb <= '0;
        else sb <= {sb[1], sb[0], ex_next};
    end

    assign fwd_rs1_sel = fwd_pick(sb, uses_rs1, rs1_addr);
    assign fwd_rs2_sel = fwd_pick(sb, uses_rs2, rs2_addr);

    // Entries only ever hold rd != 0, so x0 sources can never match here.
    assign load_use = sb[0].valid && sb[0].is_load &&
                      ((uses_rs1 && rs1_addr == sb[0].rd) || (uses_rs2 && rs2_addr == sb[0].rd));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage sequencer producing stall/bubble/flush, forwarding selects
// and the registered PC redirect for the RV32I five-stage core.
// Ports: clk_i, rstn_i (async active-low); dec_* describe the decode instruction;
// ex_redirect_i/ex_target_i report a taken control transfer from EX; stall_fetch_o,
// stall_decode_o, bubble_ex_o, flush_decode_o, flush_execute_o steer the pipeline;
// fwd_rs1_sel_o/fwd_rs2_sel_o drive the EX operand muxes; redirect_valid_o and
// redirect_pc_o load the fetch PC one cycle after the redirect.
// Optional: defining HAZARD_PERF_CNT_EN adds perf_stall_cycles_o, perf_flush_events_o
// and perf_fwd_hits_o (32-bit saturating counters).
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        dec_valid_i,
    input  logic [4:0]  dec_rs1_addr_i,
    input  logic [4:0]  dec_rs2_addr_i,
    input  logic        dec_uses_rs1_i,
    input  logic        dec_uses_rs2_i,
    input  logic [4:0]  dec_rd_addr_i,
    input  logic        dec_rd_wr_i,
    input  logic        dec_is_load_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    output logic        stall_fetch_o,
    output logic        stall_decode_o,
    output logic        bubble_ex_o,
    output logic        flush_decode_o,
    output logic        flush_execute_o,
    output logic [1:0]  fwd_rs1_sel_o,
    output logic [1:0]  fwd_rs2_sel_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_flush_events_o,
    output logic [31:0] perf_fwd_hits_o
`endif
);
    hazard_state_e state, next_state;
    logic [1:0]    cnt, next_cnt;
    logic          load_use, hazard, run_like, stall, flush, load_en;
    fwd_sel_e      fwd1, fwd2;

    hazard_scoreboard u_sb (
        .clk         (clk_i),
        .rst_n       (rstn_i),
        .load_en     (load_en),
        .rd_addr     (dec_rd_addr_i),
        .is_load     (dec_is_load_i),
        .rs1_addr    (dec_rs1_addr_i),
        .rs2_addr    (dec_rs2_addr_i),
        .uses_rs1    (dec_uses_rs1_i),
        .uses_rs2    (dec_uses_rs2_i),
        .fwd_rs1_sel (fwd1),
        .fwd_rs2_sel (fwd2),
        .load_use    (load_use)
    );

    assign hazard = dec_valid_i && load_use;
    // The hazard cycle itself is the first stall cycle, so LOAD_STALL with the
    // counter at 0 has no stall left and behaves exactly like RUN.
    assign run_like = state == RUN || (state == LOAD_STALL && cnt == 2'd0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (ex_redirect_i) begin
            next_state = FLUSH;
            next_cnt   = 2'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH) begin
            next_state = cnt == 2'd0 ? RUN : FLUSH;
            next_cnt   = cnt == 2'd0 ? 2'd0 : cnt - 2'd1;
        end else if (!run_like) begin
            next_cnt   = cnt - 2'd1;
        end else begin
            next_state = hazard ? LOAD_STALL : RUN;
            next_cnt   = hazard ? 2'(LOAD_STALL_CYCLES - 1) : 2'd0;
        end
    end

    // Flush wins over stall, and a same-cycle redirect cancels a pending stall.
    always_comb begin
        flush = state == FLUSH;
        stall = !flush && !ex_redirect_i && (!run_like || hazard);
    end

    assign load_en = dec_valid_i && dec_rd_wr_i && dec_rd_addr_i != 5'd0 &&
                     !stall && !flush && !ex_redirect_i;

    assign stall_fetch_o   = stall;
    assign stall_decode_o  = stall;
    assign bubble_ex_o     = stall;
    assign flush_decode_o  = flush;
    assign flush_execute_o = flush;
    assign fwd_rs1_sel_o   = fwd1;
    assign fwd_rs2_sel_o   = fwd2;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'd0;
        end else begin
            redirect_valid_o <= ex_redirect_i;
            if (ex_redirect_i) redirect_pc_o <= ex_target_i;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [1:0] fwd_inc;
    assign fwd_inc = {1'b0, fwd1 != FWD_RF} + {1'b0, fwd2 != FWD_RF};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_stall_cycles_o <= 32'd0;
            perf_flush_events_o <= 32'd0;
            perf_fwd_hits_o     <= 32'd0;
        end else begin
            perf_stall_cycles_o <= sat_add(perf_stall_cycles_o, {1'b0, stall});
            perf_flush_events_o <= sat_add(perf_flush_events_o, {1'b0, ex_redirect_i});
            perf_fwd_hits_o     <= sat_add(perf_fwd_hits_o, fwd_inc);
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl using an expected-output queue.
module tb_hazard_ctrl;
    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        redir;
        logic [31:0] tgt;
    } stim_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dec_valid, dec_uses_rs1, dec_uses_rs2, dec_rd_wr, dec_is_load, ex_redirect;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic [31:0] ex_target;
    logic        stall_fetch, stall_decode, bubble_ex, flush_decode, flush_execute;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [41:0] obs;
    logic [41:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    hazard_ctrl dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .dec_valid_i      (dec_valid),
        .dec_rs1_addr_i   (dec_rs1_addr),
        .dec_rs2_addr_i   (dec_rs2_addr),
        .dec_uses_rs1_i   (dec_uses_rs1),
        .dec_uses_rs2_i   (dec_uses_rs2),
        .dec_rd_addr_i    (dec_rd_addr),
        .dec_rd_wr_i      (dec_rd_wr),
        .dec_is_load_i    (dec_is_load),
        .ex_redirect_i    (ex_redirect),
        .ex_target_i      (ex_target),
        .stall_fetch_o    (stall_fetch),
        .stall_decode_o   (stall_decode),
        .bubble_ex_o      (bubble_ex),
        .flush_decode_o   (flush_decode),
        .flush_execute_o  (flush_execute),
        .fwd_rs1_sel_o    (fwd_rs1_sel),
        .fwd_rs2_sel_o    (fwd_rs2_sel),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Observed vector: {stall x3, flush x2, fwd1, fwd2, redirect_valid, pc (only while valid)}.
    assign obs = {stall_fetch, stall_decode, bubble_ex, flush_decode, flush_execute,
                  fwd_rs1_sel, fwd_rs2_sel, redirect_valid, redirect_valid ? redirect_pc : 32'h0};

    function automatic stim_t st(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                 logic [4:0] rd, logic wr, logic ld, logic redir, logic [31:0] tgt);
        return '{v, rs1, rs2, u1, u2, rd, wr, ld, redir, tgt};
    endfunction

    function automatic logic [41:0] ex(logic stall, logic flush, logic [1:0] f1, logic [1:0] f2,
                                       logic rv, logic [31:0] pc);
        return {stall, stall, stall, flush, flush, f1, f2, rv, rv ? pc : 32'h0};
    endfunction

    function automatic stim_t idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input stim_t s);
        dec_valid    = s.v;
        dec_rs1_addr = s.rs1;
        dec_rs2_addr = s.rs2;
        dec_uses_rs1 = s.u1;
        dec_uses_rs2 = s.u2;
        dec_rd_addr  = s.rd;
        dec_rd_wr    = s.wr;
        dec_is_load  = s.ld;
        ex_redirect  = s.redir;
        ex_target    = s.tgt;
    endtask

    task automatic test_reset();
        logic [41:0] e;
        rstn = 1'b1;
        apply(idle());
        #1 rstn = 1'b0;
        #7;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_outputs got %h want %h", obs, e); end
        tests++;
        if (redirect_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", redirect_pc); end
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        logic [41:0] x[$];
        logic [41:0] e;
        s.push_back(st(1, 0, 0, 1, 0, 5, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 5, 1, 1, 5, 1, 0, 0, 0));  x.push_back(ex(0, 0, 1, 1, 0, 0));
        s.push_back(st(1, 5, 5, 1, 1, 10, 1, 0, 0, 0)); x.push_back(ex(0, 0, 1, 1, 0, 0));
        repeat (3) begin s.push_back(idle()); x.push_back(ex(0, 0, 0, 0, 0, 0)); end
        s.push_back(st(1, 1, 2, 1, 1, 5, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 1, 1, 1, 6, 1, 0, 0, 0));  x.push_back(ex(0, 0, 1, 0, 0, 0));
        s.push_back(st(1, 5, 0, 1, 1, 7, 1, 0, 0, 0));  x.push_back(ex(0, 0, 2, 0, 0, 0));
        s.push_back(st(1, 5, 6, 1, 1, 8, 1, 0, 0, 0));  x.push_back(ex(0, 0, 3, 2, 0, 0));
        s.push_back(st(1, 7, 7, 1, 0, 9, 1, 0, 0, 0));  x.push_back(ex(0, 0, 2, 0, 0, 0));
        repeat (3) begin s.push_back(idle()); x.push_back(ex(0, 0, 0, 0, 0, 0)); end
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL back_to_back[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [41:0] x[$];
        logic [41:0] e;
        s.push_back(st(1, 1, 0, 1, 0, 5, 1, 1, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 2, 1, 1, 6, 1, 0, 0, 0));  x.push_back(ex(1, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 2, 1, 1, 6, 1, 0, 0, 0));  x.push_back(ex(0, 0, 2, 0, 0, 0));
        s.push_back(st(1, 1, 0, 1, 0, 8, 1, 1, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8, 1, 1, 9, 1, 0, 0, 0));  x.push_back(ex(1, 0, 0, 0, 0, 0));
        s.push_back(st(1, 1, 8, 1, 1, 9, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 2, 0, 0));
        s.push_back(st(1, 1, 0, 1, 0, 5, 1, 1, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(0, 5, 0, 1, 0, 0, 0, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 1, 0, 1, 0, 5, 1, 1, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 5, 0, 0, 7, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        repeat (3) begin s.push_back(idle()); x.push_back(ex(0, 0, 0, 0, 0, 0)); end
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL load_use[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_x0();
        stim_t s[$];
        logic [41:0] x[$];
        logic [41:0] e;
        s.push_back(st(1, 0, 0, 1, 0, 0, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 0, 0, 1, 1, 1, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 2, 0, 1, 0, 0, 1, 1, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 0, 0, 1, 1, 3, 1, 0, 0, 0));  x.push_back(ex(0, 0, 0, 0, 0, 0));
        repeat (3) begin s.push_back(idle()); x.push_back(ex(0, 0, 0, 0, 0, 0)); end
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL x0[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_redirect();
        stim_t s[$];
        logic [41:0] x[$];
        logic [41:0] e;
        s.push_back(st(1, 1, 2, 1, 1, 5, 1, 0, 1, 32'h100)); x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 0, 1, 0, 6, 1, 0, 0, 0));       x.push_back(ex(0, 1, 0, 0, 1, 32'h100));
        s.push_back(st(1, 6, 5, 1, 1, 7, 1, 0, 0, 0));       x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200)); x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h300)); x.push_back(ex(0, 1, 0, 0, 1, 32'h200));
        s.push_back(idle());                                  x.push_back(ex(0, 1, 0, 0, 1, 32'h300));
        repeat (3) begin s.push_back(idle()); x.push_back(ex(0, 0, 0, 0, 0, 0)); end
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL redirect[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_redirect_vs_load_use();
        stim_t s[$];
        logic [41:0] x[$];
        logic [41:0] e;
        s.push_back(st(1, 1, 0, 1, 0, 5, 1, 1, 0, 0));       x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 0, 1, 0, 6, 1, 0, 1, 32'h440)); x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 0, 1, 0, 8, 1, 0, 0, 0));       x.push_back(ex(0, 1, 2, 0, 1, 32'h440));
        repeat (3) begin s.push_back(idle()); x.push_back(ex(0, 0, 0, 0, 0, 0)); end
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL redirect_load_use[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t s[$];
        logic [41:0] x[$];
        logic [41:0] e;
        s.push_back(st(1, 1, 0, 1, 0, 5, 1, 1, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 5, 2, 1, 1, 6, 1, 0, 0, 0)); x.push_back(ex(1, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL pre_reset[%0d] got %h want %h", i, obs, e); end
        end
        #1 rstn = 1'b0;
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0));
        #1 e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL async_reset got %h want %h", obs, e); end
        @(posedge clk);
        exp_q.push_back(ex(0, 0, 0, 0, 0, 0));
        #1 e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL held_reset got %h want %h", obs, e); end
        rstn = 1'b1;
        s.delete();
        x.delete();
        s.push_back(st(1, 5, 5, 1, 1, 6, 1, 0, 0, 0)); x.push_back(ex(0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 6, 0, 1, 0, 7, 1, 0, 0, 0)); x.push_back(ex(0, 0, 1, 0, 0, 0));
        s.push_back(idle());                            x.push_back(ex(0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            @(posedge clk);
            #1 apply(s[i]);
            exp_q.push_back(x[i]);
            #4 e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL post_reset[%0d] got %h want %h", i, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_redirect();
        test_redirect_vs_load_use();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1);
    end
endmodule
